// File: rtl/fifo_read_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_read_ctrl
//  Description : Read-domain controller for an asynchronous FIFO. Owns the
//                binary/Gray read pointers, drives the RAM read address,
//                produces a registered empty flag from the synchronized Gray
//                write pointer, and registers RAM read data into a
//                valid-qualified output with an underflow pulse.
//                Optional macro FIFO_RD_LEVEL_EN adds r_level and
//                r_almost_empty outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_read_ctrl #(
   parameter int DATA_BITS = 8,
   parameter int ADDR_BITS = 4,
   parameter int AE_LEVEL  = 2
) (
   input  logic                 r_clk,
   input  logic                 r_rst,
   input  logic                 r_en,
   input  logic [ADDR_BITS:0]   r_q2_wptr,
   input  logic [DATA_BITS-1:0] ram_r_data,
   output logic [ADDR_BITS-1:0] r_addr,
   output logic [ADDR_BITS:0]   r_ptr,
   output logic                 r_empty,
   output logic [DATA_BITS-1:0] r_data,
   output logic                 r_valid,
`ifdef FIFO_RD_LEVEL_EN
   output logic [ADDR_BITS:0]   r_level,
   output logic                 r_almost_empty,
`endif
   output logic                 r_underflow
);

   // Binary read pointer; one extra MSB distinguishes laps around the RAM.
   logic [ADDR_BITS:0] r_bin;

   logic               w_pop;
   logic [ADDR_BITS:0] w_bin_next;
   logic [ADDR_BITS:0] w_gray_next;

   // Next-state pointer arithmetic: a read is accepted only when not empty.
   always_comb begin
      w_pop       = r_en && !r_empty;
      w_bin_next  = r_bin + {{ADDR_BITS{1'b0}}, w_pop};
      w_gray_next = (w_bin_next >> 1) ^ w_bin_next;
   end

   // RAM address comes straight from the pointer, never from r_en.
   assign r_addr = r_bin[ADDR_BITS-1:0];

   // Pointer, empty flag and read data registers.
   always_ff @(posedge r_clk) begin
      if (r_rst) begin
         r_bin       <= '0;
         r_ptr       <= '0;
         r_empty     <= 1'b1;
         r_data      <= '0;
         r_valid     <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         r_bin       <= w_bin_next;
         r_ptr       <= w_gray_next;
         // Comparing the post-pop Gray pointer lets empty assert on the same
         // edge as the final pop instead of one cycle later.
         r_empty     <= (w_gray_next == r_q2_wptr);
         r_valid     <= w_pop;
         r_underflow <= r_en && r_empty;
         if (w_pop) begin
            r_data <= ram_r_data;
         end
      end
   end

`ifdef FIFO_RD_LEVEL_EN
   localparam logic [ADDR_BITS:0] c_AE_LEVEL = (ADDR_BITS+1)'(AE_LEVEL);

   logic [ADDR_BITS:0] w_wbin;
   logic [ADDR_BITS:0] w_level_next;

   // Gray-to-binary: each binary bit is the XOR of all Gray bits at and above it.
   for (genvar i = 0; i <= ADDR_BITS; i++) begin : g_gray2bin
      assign w_wbin[i] = ^(r_q2_wptr >> i);
   end

   assign w_level_next = w_wbin - w_bin_next;

   // Fill level as seen from the read side, and the almost-empty threshold.
   always_ff @(posedge r_clk) begin
      if (r_rst) begin
         r_level        <= '0;
         r_almost_empty <= 1'b1;
      end else begin
         r_level        <= w_level_next;
         r_almost_empty <= (w_level_next <= c_AE_LEVEL);
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_read_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_read_ctrl
//  Description : Self-checking bench for fifo_read_ctrl. A word-count model
//                predicts every output each cycle; directed sequences add
//                literal expectations for reset, single word, underflow,
//                full drain, wrap-around and reset mid-burst.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_read_ctrl;

   localparam int DW = 8;
   localparam int AW = 4;
   localparam int AE = 2;

   logic          r_clk = 1'b0;
   logic          r_rst = 1'b1;
   logic          r_en  = 1'b0;
   logic [AW:0]   r_q2_wptr = '0;
   logic [DW-1:0] ram_r_data;
   logic [AW-1:0] r_addr;
   logic [AW:0]   r_ptr;
   logic          r_empty;
   logic [DW-1:0] r_data;
   logic          r_valid;
   logic          r_underflow;
`ifdef FIFO_RD_LEVEL_EN
   logic [AW:0]   r_level;
   logic          r_almost_empty;
`endif

   logic [DW-1:0] mem [0:(1<<AW)-1];

   int total = 0;
   int bad   = 0;

   fifo_read_ctrl #(.DATA_BITS(DW), .ADDR_BITS(AW), .AE_LEVEL(AE)) dut (
      .r_clk          (r_clk),
      .r_rst          (r_rst),
      .r_en           (r_en),
      .r_q2_wptr      (r_q2_wptr),
      .ram_r_data     (ram_r_data),
      .r_addr         (r_addr),
      .r_ptr          (r_ptr),
      .r_empty        (r_empty),
      .r_data         (r_data),
      .r_valid        (r_valid),
`ifdef FIFO_RD_LEVEL_EN
      .r_level        (r_level),
      .r_almost_empty (r_almost_empty),
`endif
      .r_underflow    (r_underflow)
   );

   always #5 r_clk = ~r_clk;

   // Combinational RAM model
   assign ram_r_data = mem[r_addr];

   function automatic logic [AW:0] gray(input int unsigned n);
      logic [AW:0] b;
      b = n[AW:0];
      return b ^ (b >> 1);
   endfunction

   function automatic logic [AW:0] ungray(input logic [AW:0] g);
      logic [AW:0] b;
      b = '0;
      for (int i = AW; i >= 0; i--) b[i] = g[i] ^ ((i == AW) ? 1'b0 : b[i+1]);
      return b;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model: counts words read ------------------
   logic [AW:0]   m_rd;        // words read, modulo 2*depth
   logic          m_empty, m_valid, m_under, m_ae, m_was_rst;
   logic [DW-1:0] m_data;
   logic [AW:0]   m_level;
   bit            m_init = 0;

   always @(posedge r_clk) begin
      logic [AW:0] wcount;
      logic        pop;
      m_was_rst = r_rst;
      if (r_rst) begin
         m_rd = '0; m_empty = 1; m_data = '0; m_valid = 0; m_under = 0;
         m_level = '0; m_ae = 1; m_init = 1;
      end else if (m_init) begin
         wcount  = ungray(r_q2_wptr);
         pop     = r_en && !m_empty;
         m_under = r_en && m_empty;
         m_valid = pop;
         if (pop) begin
            m_data = mem[m_rd[AW-1:0]];
            m_rd   = m_rd + 1'b1;
         end
         m_empty = (wcount == m_rd);
         m_level = wcount - m_rd;
         m_ae    = (m_level <= AE);
      end
   end

   // ---------------- per-cycle compare against the model -------------------
   logic [AW:0] prev_ptr;
   bit          have_prev = 0;
   always @(negedge r_clk) begin
      if (m_init) begin
         check("addr",      32'(r_addr),      32'(m_rd[AW-1:0]));
         check("ptr",       32'(r_ptr),       32'(gray(32'(m_rd))));
         check("empty",     32'(r_empty),     32'(m_empty));
         check("data",      32'(r_data),      32'(m_data));
         check("valid",     32'(r_valid),     32'(m_valid));
         check("underflow", 32'(r_underflow), 32'(m_under));
`ifdef FIFO_RD_LEVEL_EN
         check("level",     32'(r_level),        32'(m_level));
         check("almost_e",  32'(r_almost_empty), 32'(m_ae));
`endif
         if (have_prev && !m_was_rst && r_ptr != prev_ptr)
            check("ptr_onebit", 32'($countones(r_ptr ^ prev_ptr)), 32'd1);
         prev_ptr  = r_ptr;
         have_prev = 1;
      end
   end

   task automatic step();
      @(posedge r_clk);
      #1;
   endtask

   // ---------------- directed stimulus -------------------------------------
   initial begin
      int valids, spurious, addr_wraps;
      bit saw_wrap;
      logic [AW-1:0] pa;
      logic [AW:0]   pp;
      for (int i = 0; i < (1<<AW); i++) mem[i] = 8'(i);
      mem[0] = 8'hA5;

      // 1. reset with r_en high
      r_rst = 1; r_en = 1; r_q2_wptr = '0;
      step(); step();
      check("rst_empty", 32'(r_empty), 32'd1);
      check("rst_ptr",   32'(r_ptr),   32'd0);
      check("rst_addr",  32'(r_addr),  32'd0);
      check("rst_valid", 32'(r_valid), 32'd0);
      check("rst_data",  32'(r_data),  32'd0);
      check("rst_under", 32'(r_underflow), 32'd0);

      // 2. single word
      r_rst = 0; r_en = 0; r_q2_wptr = 5'b00001;
      step();
      check("sw_not_empty", 32'(r_empty), 32'd0);
      r_en = 1;
      step();
      check("sw_data",  32'(r_data),  32'hA5);
      check("sw_valid", 32'(r_valid), 32'd1);
      check("sw_ptr",   32'(r_ptr),   32'b00001);
      check("sw_addr",  32'(r_addr),  32'd1);
      check("sw_empty", 32'(r_empty), 32'd1);

      // 3. underflow
      step();
      check("uf_pulse", 32'(r_underflow), 32'd1);
      check("uf_valid", 32'(r_valid),     32'd0);
      check("uf_ptr",   32'(r_ptr),       32'b00001);
      check("uf_data",  32'(r_data),      32'hA5);
      r_en = 0;
      step();
      check("uf_clear", 32'(r_underflow), 32'd0);

      // 4. full drain of 16 words
      mem[0] = 8'h00;
      r_rst = 1; step();
      r_rst = 0; r_q2_wptr = 5'b11000;
      step();
      check("fd_not_empty", 32'(r_empty), 32'd0);
      r_en = 1; valids = 0;
      for (int i = 0; i < 16; i++) begin
         step();
         if (r_valid) valids++;
         if (i < 15) check("fd_empty_early", 32'(r_empty), 32'd0);
      end
      check("fd_valids", 32'(valids),  32'd16);
      check("fd_last",   32'(r_data),  32'h0F);
      check("fd_empty",  32'(r_empty), 32'd1);
      check("fd_ptr",    32'(r_ptr),   32'b11000);
      step();
      check("fd_under",  32'(r_underflow), 32'd1);

      // 5. wrap: writer 3 words ahead, 40 continuous pops
      for (int i = 0; i < (1<<AW); i++) mem[i] = 8'(i * 17 + 3);
      r_en = 0; r_q2_wptr = gray(19);
      step();
      valids = 0; spurious = 0; addr_wraps = 0; saw_wrap = 0;
      pa = r_addr; pp = r_ptr;
      for (int i = 1; i <= 40; i++) begin
         r_q2_wptr = gray((19 + i > 56) ? 56 : 19 + i);
         r_en = 1;
         step();
         if (r_valid) valids++;
         if (i < 40 && r_empty) spurious++;
         if (pa == 4'd15 && r_addr == 4'd0) addr_wraps++;
         if (pp == 5'b10000 && r_ptr == 5'b00000) saw_wrap = 1;
         pa = r_addr; pp = r_ptr;
      end
      check("wr_valids",   32'(valids),     32'd40);
      check("wr_spurious", 32'(spurious),   32'd0);
      check("wr_addrwrap", 32'(addr_wraps), 32'd2);
      check("wr_ptrwrap",  32'(saw_wrap),   32'd1);
      check("wr_empty",    32'(r_empty),    32'd1);

      // 6. reset mid-burst (plus level when enabled)
      r_en = 0; r_rst = 1; step();
      r_rst = 0; r_q2_wptr = gray(6);
      step();
      r_en = 1;
      step(); step(); step(); step();
      check("mb_ptr4", 32'(r_ptr), 32'(gray(4)));
`ifdef FIFO_RD_LEVEL_EN
      check("mb_level", 32'(r_level),        32'd2);
      check("mb_ae",    32'(r_almost_empty), 32'd1);
`endif
      r_rst = 1;
      step();
      check("mb_rst_ptr",   32'(r_ptr),   32'd0);
      check("mb_rst_valid", 32'(r_valid), 32'd0);
      check("mb_rst_empty", 32'(r_empty), 32'd1);
`ifdef FIFO_RD_LEVEL_EN
      check("mb_rst_level", 32'(r_level), 32'd0);
`endif
      r_rst = 0; r_en = 0;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
